// File: rtl/trig_clk_phase_seq.sv
// MMCM dynamic phase-shift sequencer.
// Issues a run of single PSEN pulses, one per requested step, waiting for
// PSDONE after each before issuing the next. Tracks completed steps and a
// wrapping signed net position; a step that never completes raises a sticky
// error flag and ends the run.
`timescale 1ns/1ps

module trig_clk_phase_seq #(
  parameter int pSTEP_WIDTH     = 16,
  parameter int pPOS_WIDTH      = 16,
  parameter int pTIMEOUT_CYCLES = 1024
) (
  input  logic                          cwusb_clk,
  input  logic                          reset_n,
  input  logic                          I_start,
  input  logic [pSTEP_WIDTH-1:0]        I_steps,
  input  logic                          I_dir,
  input  logic                          I_abort,
  input  logic                          I_pos_clear,
  output logic                          O_psen,
  output logic                          O_psincdec,
  input  logic                          I_psdone,
  output logic                          O_busy,
  output logic                          O_done,
  output logic                          O_error,
  output logic [pSTEP_WIDTH-1:0]        O_steps_done,
  output logic signed [pPOS_WIDTH-1:0]  O_position
);

  // Timeout counter only needs to reach pTIMEOUT_CYCLES-1; the +1 keeps the
  // width non-zero when the timeout is a single cycle.
  localparam int lpTO_W = $clog2(pTIMEOUT_CYCLES + 1);
  localparam logic [lpTO_W-1:0] lpTO_LAST = lpTO_W'(pTIMEOUT_CYCLES - 1);
  localparam logic [lpTO_W-1:0] lpTO_ONE  = lpTO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                         r_state;
  logic [pSTEP_WIDTH-1:0]         r_steps;
  logic                           r_dir;
  logic                           r_abort_pend;
  logic [lpTO_W-1:0]              r_to_cnt;
  logic                           r_psen;
  logic                           r_psincdec;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_error;
  logic [pSTEP_WIDTH-1:0]         r_steps_done;
  logic signed [pPOS_WIDTH-1:0]   r_position;

  logic [pSTEP_WIDTH-1:0]         w_steps_inc;
  logic signed [pPOS_WIDTH-1:0]   w_pos_next;
  logic                           w_last_step;
  logic                           w_stop;
  logic                           w_timeout;

  // Completion arithmetic: count and position move together on PSDONE.
  // Position wraps naturally in two's complement (no saturation).
  assign w_steps_inc = r_steps_done + pSTEP_WIDTH'(1);
  assign w_pos_next  = r_dir ? (r_position + pPOS_WIDTH'(1))
                             : (r_position - pPOS_WIDTH'(1));
  assign w_last_step = (w_steps_inc == r_steps);
  // An abort arriving on the very cycle PSDONE lands still ends the run.
  assign w_stop      = w_last_step | r_abort_pend | I_abort;
  assign w_timeout   = (r_to_cnt == lpTO_LAST);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge cwusb_clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_steps      <= '0;
      r_dir        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_to_cnt     <= '0;
      r_psen       <= 1'b0;
      r_psincdec   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_steps_done <= '0;
      r_position   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (I_pos_clear) begin
            r_position <= '0;
          end
          if (I_start) begin
            r_error      <= 1'b0;
            r_steps_done <= '0;
            r_abort_pend <= 1'b0;
            if (I_steps != '0) begin
              // PSEN goes high on the cycle right after start is sampled.
              r_steps    <= I_steps;
              r_dir      <= I_dir;
              r_psincdec <= I_dir;
              r_psen     <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_PULSE;
            end else begin
              // Empty request completes immediately without touching the MMCM.
              r_done <= 1'b1;
            end
          end
        end

        ST_PULSE: begin
          // PSEN is high for exactly this one cycle.
          r_psen   <= 1'b0;
          r_to_cnt <= '0;
          if (I_abort) begin
            r_abort_pend <= 1'b1;
          end
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (I_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (I_psdone) begin
            r_steps_done <= w_steps_inc;
            r_position   <= w_pos_next;
            if (w_stop) begin
              r_abort_pend <= 1'b0;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_psen  <= 1'b1;
              r_state <= ST_PULSE;
            end
          end else if (w_timeout) begin
            // Failed step: no count or position change.
            r_abort_pend <= 1'b0;
            r_error      <= 1'b1;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + lpTO_ONE;
          end
        end

        default: begin
          r_psen  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_psen       = r_psen;
  assign O_psincdec   = r_psincdec;
  assign O_busy       = r_busy;
  assign O_done       = r_done;
  assign O_error      = r_error;
  assign O_steps_done = r_steps_done;
  assign O_position   = r_position;

endmodule

// File: tb/tb_trig_clk_phase_seq.sv
// Bench for the phase-shift sequencer: reset check, a table of directed runs,
// hand-written corner sequences and randomized runs against a run-level model.
`timescale 1ns/1ps

module tb_trig_clk_phase_seq;

  localparam int SW = 8;
  localparam int PW = 4;
  localparam int TO = 16;

  logic                 cwusb_clk;
  logic                 reset_n;
  logic                 I_start;
  logic [SW-1:0]        I_steps;
  logic                 I_dir;
  logic                 I_abort;
  logic                 I_pos_clear;
  logic                 O_psen;
  logic                 O_psincdec;
  logic                 I_psdone;
  logic                 O_busy;
  logic                 O_done;
  logic                 O_error;
  logic [SW-1:0]        O_steps_done;
  logic signed [PW-1:0] O_position;

  trig_clk_phase_seq #(
    .pSTEP_WIDTH    (SW),
    .pPOS_WIDTH     (PW),
    .pTIMEOUT_CYCLES(TO)
  ) dut (
    .cwusb_clk   (cwusb_clk),
    .reset_n     (reset_n),
    .I_start     (I_start),
    .I_steps     (I_steps),
    .I_dir       (I_dir),
    .I_abort     (I_abort),
    .I_pos_clear (I_pos_clear),
    .O_psen      (O_psen),
    .O_psincdec  (O_psincdec),
    .I_psdone    (I_psdone),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_error     (O_error),
    .O_steps_done(O_steps_done),
    .O_position  (O_position)
  );

  initial begin
    cwusb_clk = 1'b0;
    forever #5 cwusb_clk = ~cwusb_clk;
  end

  int checks = 0;
  int errors = 0;

  // Monitor state
  int cyc = 0;
  int psen_cnt = 0;
  int done_cnt = 0;
  int psen_cyc = 0;
  int done_cyc = 0;
  bit prev_psen = 1'b0;
  bit exp_dir = 1'b0;

  // Stimulus controls
  int dly[8];        // PSDONE delay per step in cycles; 0 = never answer
  bit inj_start = 1'b0;
  int pos_model = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int wrap4(input int v);
    int m;
    m = (((v + 8) % 16) + 16) % 16;
    return m - 8;
  endfunction

  // Cycle monitor sampling just after each rising edge.
  initial begin
    forever begin
      @(posedge cwusb_clk);
      #1;
      cyc++;
      if (O_psen) begin
        psen_cnt++;
        psen_cyc = cyc;
        chk("psen_single_cycle", int'(prev_psen), 0);
        chk("psincdec_dir", int'(O_psincdec), int'(exp_dir));
      end
      if (O_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_busy_low", int'(O_busy), 0);
      end
      prev_psen = O_psen;
    end
  end

  // One full run: start, answer each PSEN per dly[], optional abort/inject,
  // then compare the run's outcome against the supplied expectations.
  task automatic run_seq(input string nm, input int s, input bit d, input int ab,
                         input int e_sd, input int e_pos, input bit e_err, input int e_pul);
    int p0, d0, n, k, last_d;
    bit fin;
    p0 = psen_cnt;
    d0 = done_cnt;
    exp_dir = d;
    last_d = 0;
    @(negedge cwusb_clk);
    I_start = 1'b1; I_steps = SW'(s); I_dir = d;
    @(negedge cwusb_clk);
    I_start = 1'b0;
    chk({nm, "_err_cleared"}, int'(O_error), 0);
    chk({nm, "_busy_after_start"}, int'(O_busy), 1);
    chk({nm, "_psen_after_start"}, int'(O_psen), 1);
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      n = 0;
      while (!O_psen && n < 50) begin
        @(negedge cwusb_clk);
        n++;
      end
      if (!O_psen) begin
        chk({nm, "_psen_wait_expired"}, 0, 1);
        fin = 1'b1;
      end else begin
        last_d = dly[k];
        @(negedge cwusb_clk);
        if (k == ab) I_abort = 1'b1;
        if (inj_start && k == 0) begin
          I_start = 1'b1; I_steps = SW'(1); I_dir = ~d;
        end
        if (dly[k] == 0) begin
          @(negedge cwusb_clk);
          I_abort = 1'b0; I_start = 1'b0;
          fin = 1'b1;
        end else begin
          repeat (dly[k] - 1) begin
            @(negedge cwusb_clk);
            I_abort = 1'b0; I_start = 1'b0;
          end
          I_psdone = 1'b1;
          @(negedge cwusb_clk);
          I_psdone = 1'b0; I_abort = 1'b0; I_start = 1'b0;
          k++;
          if (k >= s || (k - 1) == ab) fin = 1'b1;
        end
      end
    end
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge cwusb_clk);
      n++;
    end
    chk({nm, "_done_seen"}, int'(done_cnt != d0), 1);
    chk({nm, "_done_latency"}, done_cyc - psen_cyc, (last_d == 0) ? TO + 1 : last_d + 1);
    repeat (3) @(negedge cwusb_clk);
    chk({nm, "_done_count"}, done_cnt - d0, 1);
    chk({nm, "_psen_count"}, psen_cnt - p0, e_pul);
    chk({nm, "_steps_done"}, int'(O_steps_done), e_sd);
    chk({nm, "_position"}, int'(O_position), e_pos);
    chk({nm, "_error"}, int'(O_error), int'(e_err));
    chk({nm, "_busy_end"}, int'(O_busy), 0);
    $display("seq %s steps=%0d dir=%0d abort_at=%0d -> steps_done=%0d pos=%0d err=%0d psen=%0d",
             nm, s, d, ab, O_steps_done, O_position, O_error, psen_cnt - p0);
  endtask

  typedef struct {
    int steps;
    bit dir;
    int dly;
    int ab;
    int e_sd;
    int e_pos;
    bit e_err;
    int e_pul;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int p0, d0, n;
    int s, ab, comp, pul;
    bit d, er;

    tbl[0] = '{3, 1'b1, 5, -1, 3,  3, 1'b0, 3};  // basic 3-step increment
    tbl[1] = '{5, 1'b0, 3,  1, 2,  1, 1'b0, 2};  // abort during step 2
    tbl[2] = '{1, 1'b1, 0, -1, 0,  1, 1'b1, 1};  // PSDONE never arrives
    tbl[3] = '{2, 1'b1, 2, -1, 2,  3, 1'b0, 2};  // start clears error
    tbl[4] = '{4, 1'b1, 1, -1, 4,  7, 1'b0, 4};  // back-to-back PSDONE
    tbl[5] = '{1, 1'b1, 4, -1, 1, -8, 1'b0, 1};  // +1 from 7 wraps to -8
    tbl[6] = '{2, 1'b0, 1, -1, 2,  6, 1'b0, 2};  // -2 from -8 wraps to 6

    reset_n = 1'b0; I_start = 1'b0; I_steps = '0; I_dir = 1'b0;
    I_abort = 1'b0; I_pos_clear = 1'b0; I_psdone = 1'b0;
    for (int i = 0; i < 8; i++) dly[i] = 1;

    repeat (3) @(negedge cwusb_clk);
    chk("rst_psen", int'(O_psen), 0);
    chk("rst_psincdec", int'(O_psincdec), 0);
    chk("rst_busy", int'(O_busy), 0);
    chk("rst_done", int'(O_done), 0);
    chk("rst_error", int'(O_error), 0);
    chk("rst_steps_done", int'(O_steps_done), 0);
    chk("rst_position", int'(O_position), 0);
    reset_n = 1'b1;
    @(negedge cwusb_clk);

    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 8; i++) dly[i] = tbl[r].dly;
      run_seq($sformatf("tbl%0d", r), tbl[r].steps, tbl[r].dir, tbl[r].ab,
              tbl[r].e_sd, tbl[r].e_pos, tbl[r].e_err, tbl[r].e_pul);
    end

    // Position clear in IDLE
    @(negedge cwusb_clk); I_pos_clear = 1'b1;
    @(negedge cwusb_clk); I_pos_clear = 1'b0;
    chk("pos_clear", int'(O_position), 0);
    pos_model = 0;

    // PSDONE in IDLE must be ignored
    @(negedge cwusb_clk); I_psdone = 1'b1;
    @(negedge cwusb_clk); I_psdone = 1'b0;
    @(negedge cwusb_clk);
    chk("idle_psdone_sd", int'(O_steps_done), 2);
    chk("idle_psdone_pos", int'(O_position), 0);

    // Abort in IDLE must not leak into the next run
    @(negedge cwusb_clk); I_abort = 1'b1;
    @(negedge cwusb_clk); I_abort = 1'b0;
    for (int i = 0; i < 8; i++) dly[i] = 2;
    run_seq("idle_abort", 2, 1'b1, -1, 2, 2, 1'b0, 2);
    pos_model = 2;

    // Timeout, then a zero-step start clears the error
    dly[0] = 0;
    run_seq("timeout", 1, 1'b0, -1, 0, 2, 1'b1, 1);
    p0 = psen_cnt;
    d0 = done_cnt;
    @(negedge cwusb_clk); I_start = 1'b1; I_steps = '0; I_dir = 1'b1;
    @(negedge cwusb_clk); I_start = 1'b0;
    chk("zero_done", int'(O_done), 1);
    chk("zero_busy", int'(O_busy), 0);
    chk("zero_error_cleared", int'(O_error), 0);
    chk("zero_steps_done", int'(O_steps_done), 0);
    @(negedge cwusb_clk);
    chk("zero_done_one_cycle", int'(O_done), 0);
    chk("zero_busy_later", int'(O_busy), 0);
    chk("zero_no_psen", psen_cnt - p0, 0);
    chk("zero_done_count", done_cnt - d0, 1);
    chk("zero_position", int'(O_position), 2);

    // Second start while busy is ignored
    for (int i = 0; i < 8; i++) dly[i] = 3;
    inj_start = 1'b1;
    run_seq("busy_start", 3, 1'b1, -1, 3, 5, 1'b0, 3);
    inj_start = 1'b0;

    // Reset in WAIT: everything clears, no done pulse
    d0 = done_cnt;
    @(negedge cwusb_clk); I_start = 1'b1; I_steps = SW'(3); I_dir = 1'b1; exp_dir = 1'b1;
    @(negedge cwusb_clk); I_start = 1'b0;
    @(negedge cwusb_clk); I_psdone = 1'b1;
    @(negedge cwusb_clk); I_psdone = 1'b0;
    n = 0;
    while (!O_psen && n < 20) begin
      @(negedge cwusb_clk);
      n++;
    end
    @(negedge cwusb_clk);
    reset_n = 1'b0;
    @(negedge cwusb_clk);
    chk("wait_rst_psen", int'(O_psen), 0);
    chk("wait_rst_busy", int'(O_busy), 0);
    chk("wait_rst_position", int'(O_position), 0);
    chk("wait_rst_steps_done", int'(O_steps_done), 0);
    reset_n = 1'b1;
    p0 = psen_cnt;
    repeat (5) @(negedge cwusb_clk);
    chk("wait_rst_no_done", done_cnt - d0, 0);
    chk("wait_rst_no_psen", psen_cnt - p0, 0);
    pos_model = 0;

    // Randomized runs against a run-level model
    for (int t = 0; t < 14; t++) begin
      s = $urandom_range(1, 5);
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++)
        dly[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, s - 1) : -1;
      comp = 0; pul = 0; er = 1'b0;
      for (int i = 0; i < s; i++) begin
        pul++;
        if (dly[i] == 0) begin
          er = 1'b1;
          break;
        end
        comp++;
        if (i == ab) break;
      end
      pos_model = wrap4(pos_model + (d ? comp : -comp));
      run_seq($sformatf("rnd%0d", t), s, d, ab, comp, pos_model, er, pul);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge cwusb_clk); I_pos_clear = 1'b1;
        @(negedge cwusb_clk); I_pos_clear = 1'b0;
        pos_model = 0;
        chk($sformatf("rnd%0d_clear", t), int'(O_position), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trig_clk_phase_seq.md
TRIG_CLK_PHASE_SEQ -- requirements
Module: trig_clk_phase_seq

Interface
REQ-001 SHALL have parameter pSTEP_WIDTH, default 16: width of the step-count and progress fields.
REQ-002 SHALL have parameter pPOS_WIDTH, default 16: width of the signed net-position accumulator.
REQ-003 SHALL have parameter pTIMEOUT_CYCLES, default 1024: maximum WAIT cycles before a step is declared failed.
REQ-004 SHALL have port cwusb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port I_start, input, 1 bit: request pulse, accepted only in IDLE.
REQ-007 SHALL have port I_steps, input, pSTEP_WIDTH bits: unsigned step count, latched on accepted start.
REQ-008 SHALL have port I_dir, input, 1 bit: direction (1 = increment, 0 = decrement), latched on accepted start.
REQ-009 SHALL have port I_abort, input, 1 bit: stop after the outstanding step completes.
REQ-010 SHALL have port I_pos_clear, input, 1 bit: zero the position accumulator; honoured in IDLE only.
REQ-011 SHALL have port O_psen, output, 1 bit: MMCM phase-shift enable.
REQ-012 SHALL have port O_psincdec, output, 1 bit: MMCM phase-shift direction.
REQ-013 SHALL have port I_psdone, input, 1 bit: MMCM phase-shift complete.
REQ-014 SHALL have port O_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port O_done, output, 1 bit: one-cycle pulse marking the end of a sequence.
REQ-016 SHALL have port O_error, output, 1 bit: sticky timeout flag, cleared on the next accepted start.
REQ-017 SHALL have port O_steps_done, output, pSTEP_WIDTH bits: steps completed in the current or last sequence.
REQ-018 SHALL have port O_position, output, pPOS_WIDTH bits, signed: net completed steps since reset or the last clear.

Function
REQ-019 SHALL implement states IDLE, PULSE and WAIT; all outputs SHALL be registered.
REQ-020 IDLE, I_start=1, I_steps!=0: latch steps and dir, clear O_steps_done and O_error, go to PULSE.
REQ-021 IDLE, I_start=1, I_steps=0: stay in IDLE, pulse O_done the next cycle, issue no O_psen, clear O_error, zero O_steps_done.
REQ-022 I_start SHALL be ignored outside IDLE, with no effect on the latched parameters.
REQ-023 PULSE: O_psen=1 for exactly one cycle, O_psincdec = latched dir, timeout counter cleared, then go to WAIT unconditionally.
REQ-024 O_psen high cycle SHALL be the cycle after I_start is sampled; O_psincdec SHALL hold the latched dir from PULSE until the sequence ends.
REQ-025 WAIT, I_psdone=1: O_steps_done +1 and O_position +1 (dir=1) or -1 (dir=0), both updated on the same edge.
REQ-026 WAIT, I_psdone=1, last step or abort pending: go to IDLE, pulse O_done once, drop O_busy in that same cycle.
REQ-027 WAIT, I_psdone=1, otherwise: go to PULSE, giving the next O_psen the cycle after I_psdone.
REQ-028 WAIT, I_psdone=0 for pTIMEOUT_CYCLES consecutive cycles: set O_error, go to IDLE, pulse O_done, leave O_steps_done and O_position unchanged for the failed step.
REQ-029 I_psdone outside WAIT SHALL be ignored, with no count or position change.
REQ-030 I_abort in PULSE or WAIT SHALL set abort-pending; the outstanding step is never abandoned, and ends through REQ-026 or REQ-028; I_abort in IDLE SHALL be ignored.
REQ-031 O_position SHALL wrap modulo 2^pPOS_WIDTH in two's complement, without saturation.
REQ-032 I_pos_clear and a position update never coincide, because I_pos_clear is IDLE-only.
REQ-033 At most one O_psen SHALL be outstanding at any time.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force IDLE and clear abort-pending and the timeout counter.
REQ-035 reset_n=0 at a clock edge SHALL drive O_psen, O_psincdec, O_busy, O_done, O_error to 0 and O_steps_done, O_position to 0.
REQ-036 Reset mid-sequence SHALL produce no O_done pulse.

Verification
REQ-037 Steps=3, dir=1, I_psdone 5 cycles after each O_psen -> three 1-cycle O_psen pulses, O_psincdec=1, one O_done, O_steps_done=3, O_position=3.
REQ-038 Steps=0 -> O_done the next cycle, O_psen never high, O_busy never high, O_position unchanged.
REQ-039 pTIMEOUT_CYCLES=16, I_psdone held low -> one O_psen, O_error=1 and O_done after 16 WAIT cycles, O_steps_done=0; the next start clears O_error.
REQ-040 Steps=5, dir=0, I_abort during step 2 WAIT -> step 2 completes, O_done, O_steps_done=2, O_position=-2, no third O_psen.
REQ-041 Second I_start while busy -> ignored, original count honoured; then reset_n=0 in WAIT -> O_psen=0, O_busy=0, O_position=0, no O_done.
REQ-042 pPOS_WIDTH=4, position 7, one increment step -> O_position=-8; I_pos_clear in IDLE -> 0.
